// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: keeps a single-cycle-latency instruction memory streaming
// into a 2-entry skid FIFO that feeds decode, with redirect and reset flushing.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);

    logic [31:0] fpc;
    logic [31:0] req_pc;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic [31:0] tail_pc;
    logic [31:0] tail_instr;
    logic [1:0]  occ;
    logic        inflight;
    logic        drop;

    logic        pop;
    logic        push;
    logic [1:0]  demand;

    assign if_valid = (occ != 2'd0);
    assign if_pc    = head_pc;
    assign if_instr = head_instr;

    assign pop  = if_valid & id_ready;
    assign push = inflight & ~drop;

    // Slots that will be occupied after this edge if no new request is made;
    // requesting only while this is below 2 guarantees the FIFO cannot overflow.
    assign demand   = occ + {1'b0, inflight} - {1'b0, pop};
    assign imem_req = rst_n & ~redirect_valid & (demand < 2'd2);
    assign imem_addr = {fpc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc      <= {RESET_PC[31:2], 2'b00};
            occ      <= 2'd0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fpc    <= fpc + 32'd4;
                req_pc <= fpc;
            end
            if (inflight && drop) begin
                drop <= 1'b0;
            end

            // A redirect flushes everything; the response arriving now is discarded
            // with the flush, so drop only matters for a request still outstanding.
            if (redirect_valid) begin
                occ  <= 2'd0;
                fpc  <= {redirect_pc[31:2], 2'b00};
                drop <= imem_req;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (occ == 2'd0) begin
                            head_pc    <= req_pc;
                            head_instr <= imem_rdata;
                        end else begin
                            tail_pc    <= req_pc;
                            tail_instr <= imem_rdata;
                        end
                        occ <= occ + 2'd1;
                    end
                    2'b01: begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        occ        <= occ - 2'd1;
                    end
                    2'b11: begin
                        if (occ == 2'd1) begin
                            head_pc    <= req_pc;
                            head_instr <= imem_rdata;
                        end else begin
                            head_pc    <= tail_pc;
                            head_instr <= tail_instr;
                            tail_pc    <= req_pc;
                            tail_instr <= imem_rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
